ram_reader: RTL and testbench

//  Read-back stage for the 64-bit x 16K block RAM that the RAM write stage fills.

---
 rtl/ram_reader.sv | 127 ++++++++++++
 tb/tb_ram_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_reader.sv
// Read-back stage for the 64-bit block RAM: issues one read per word, waits out the
// RAM latency, then streams the four 16-bit lanes (lowest first) over valid/ready.
module ram_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int WORD_W     = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_num_words,
    output logic [ADDR_W-1:0] o_rd_address,
    output logic              o_rd_en,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SHIFT, DONE} state_t;

    localparam logic [2:0]    WAIT_LAST = 3'(RD_LATENCY - 1);
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   rd_address;
    logic [ADDR_W:0]     remaining;
    logic [2:0]          wait_cnt;
    logic [1:0]          lane;
    logic [DATA_W-1:0]   shreg;
    logic                accept;
    logic                last_lane;
    logic                wait_hit;

    assign accept    = (state == SHIFT) && i_ready;
    assign last_lane = accept && (lane == 2'd3);
    assign wait_hit  = (state == WAIT) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = (i_num_words == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (wait_hit) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_lane) begin
                    state_nxt = (remaining == ONE) ? DONE : ISSUE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The read address only moves on the way into ISSUE, so it holds between reads
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            rd_address <= '0;
            remaining  <= '0;
            wait_cnt   <= '0;
            lane       <= '0;
            shreg      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_start && (i_num_words != '0)) begin
                        rd_address <= i_base_addr;
                        remaining  <= i_num_words;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (wait_hit) begin
                        shreg <= i_rd_data;
                        lane  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            remaining <= remaining - ONE;
                            if (remaining != ONE) begin
                                rd_address <= rd_address + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_data = shreg[WORD_W-1:0];
        case (lane)
            2'd0:    o_data = shreg[0*WORD_W +: WORD_W];
            2'd1:    o_data = shreg[1*WORD_W +: WORD_W];
            2'd2:    o_data = shreg[2*WORD_W +: WORD_W];
            default: o_data = shreg[3*WORD_W +: WORD_W];
        endcase
    end

    assign o_rd_address = rd_address;
    assign o_rd_en      = (state == ISSUE);
    assign o_valid      = (state == SHIFT);
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: a latency-modelled RAM plus a queue-based reference of the
// expected read addresses and output words for each transfer.
module tb_ram_reader;

    localparam int AW  = 14;
    localparam int RDL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic [AW-1:0] rd_address;
    logic          rd_en;
    logic [63:0]   rd_data;
    logic [15:0]   data;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [63:0]   mem [0:16383];
    logic [RDL-1:0] pv;
    logic [AW-1:0] pa [0:RDL-1];

    ram_reader #(.ADDR_W(AW), .DATA_W(64), .WORD_W(16), .RD_LATENCY(RDL)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
        .i_num_words(num_words), .o_rd_address(rd_address), .o_rd_en(rd_en),
        .i_rd_data(rd_data), .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    // RAM model: data appears RDL cycles after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv[0] <= rd_en;
            pa[0] <= rd_address;
            for (int i = 1; i < RDL; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end
    assign rd_data = pv[RDL-1] ? mem[pa[RDL-1]] : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < 16384; k++) begin
            logic [15:0] w0, w1, w2, w3;
            w0 = 16'(4 * k);
            w1 = 16'(4 * k + 1);
            w2 = 16'(4 * k + 2);
            w3 = 16'(4 * k + 3);
            mem[k] = {w3, w2, w1, w0};
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16384; k++) begin
            mem[k] = {$urandom, $urandom};
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        logic r;
        case (mode)
            0:       r = 1'b1;
            1:       r = (k % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
        endcase
        return r;
    endfunction

    // One whole transfer: start, check every strobe/word against the model, wait for done
    task automatic run_xfer(input logic [AW-1:0] base, input logic [AW:0] n, input int mode,
                            input bit poke_busy, output int first_rd, output int first_vld,
                            output int done_cyc);
        logic [15:0]   exp_w [$];
        logic [AW-1:0] exp_a [$];
        int cyc;
        int limit;
        int k;
        bit got_done;
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i);
            exp_a.push_back(a);
            for (int l = 0; l < 4; l++) exp_w.push_back(mem[a][16*l +: 16]);
        end
        first_rd = -1; first_vld = -1; done_cyc = -1;
        cyc = 0; k = 0; got_done = 1'b0;
        limit = 100 + int'(n) * (RDL + 5) * 10;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_words = n; ready = ready_for(mode, k);
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); num_words = (AW+1)'($urandom);
        while (!got_done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_a.size() == 0) chk("extra_rd_en", 64'(rd_address), 64'hFFFF_FFFF);
                else chk("rd_address", 64'(rd_address), 64'(exp_a.pop_front()));
            end
            if (valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (exp_w.size() == 0) chk("extra_word", 64'(data), 64'hFFFF_FFFF);
                else begin
                    chk("data", 64'(data), 64'(exp_w[0]));
                    if (ready) void'(exp_w.pop_front());
                end
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                k++;
                ready = ready_for(mode, k);
                start = poke_busy && (cyc == 2);
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(got_done), 64'd1);
        chk("words_left", 64'(exp_w.size()), 64'd0);
        chk("reads_left", 64'(exp_a.size()), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_done", {61'd0, busy, done, valid}, 64'd0);
    endtask

    initial begin
        int frd, fvld, dcyc;
        int cyc;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; ready = 1'b0;
        fill_pattern();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rd_address, data, 5'(0), rd_en, valid, busy, done, 1'b0} , 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Writer pattern, full-rate consumer: words 0..7, latency and throughput
        run_xfer(14'd0, 15'd2, 0, 1'b0, frd, fvld, dcyc);
        chk("t2_rd_en_cycle", 64'(frd), 64'd1);
        chk("t2_first_valid_cycle", 64'(fvld), 64'(2 + RDL));
        chk("t1_done_cycle", 64'(dcyc), 64'(1 + 2 * (RDL + 5)));

        // Backpressure 1,0,0 pattern; stalled words are rechecked every cycle
        run_xfer(14'd0, 15'd2, 1, 1'b0, frd, fvld, dcyc);

        // Address wrap
        run_xfer(14'h3FFF, 15'd2, 0, 1'b0, frd, fvld, dcyc);
        chk("t4_first_valid_cycle", 64'(fvld), 64'(2 + RDL));

        // Zero-length transfer, then a start while busy that must be ignored
        run_xfer(14'd5, 15'd0, 0, 1'b0, frd, fvld, dcyc);
        chk("t5_done_cycle", 64'(dcyc), 64'd1);
        chk("t5_no_rd_en", 64'(frd), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t5_no_valid", 64'(fvld), 64'hFFFF_FFFF_FFFF_FFFF);
        run_xfer(14'd9, 15'd3, 1, 1'b1, frd, fvld, dcyc);

        // Reset while presenting lane 2
        @(posedge clk); #1;
        start = 1'b1; base_addr = 14'd0; num_words = 15'd2; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(valid && data == 16'd2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_reached_lane2", 64'(valid && data == 16'd2), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_outputs_zero", {rd_address, data, 5'(0), rd_en, valid, busy, done, 1'b0}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_done", {62'd0, done, busy}, 64'd0);
        end
        run_xfer(14'd0, 15'd2, 0, 1'b0, frd, fvld, dcyc);
        chk("t6_restart_done_cycle", 64'(dcyc), 64'(1 + 2 * (RDL + 5)));

        // Random RAM contents, random bases (one near the wrap), random ready
        fill_random();
        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] b;
            b = (r == 0) ? 14'h3FFD : AW'($urandom);
            run_xfer(b, (AW+1)'($urandom_range(1, 4)), 2, 1'b1, frd, fvld, dcyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
